// File: rtl/fc_pkg.sv
// Shared constants for the ETROC2 fast-command receiver: command codes,
// on-wire symbols, alignment FSM states and small symbol helpers.
package fc_pkg;

  localparam logic [3:0] CMD_IDLE       = 4'd0;
  localparam logic [3:0] CMD_LINK_RESET = 4'd1;
  localparam logic [3:0] CMD_BCR        = 4'd2;
  localparam logic [3:0] CMD_STP        = 4'd3;
  localparam logic [3:0] CMD_L1ACR      = 4'd4;
  localparam logic [3:0] CMD_CHARGE_INJ = 4'd5;
  localparam logic [3:0] CMD_L1A        = 4'd6;
  localparam logic [3:0] CMD_L1A_BCR    = 4'd7;
  localparam logic [3:0] CMD_WS_START   = 4'd8;
  localparam logic [3:0] CMD_WS_STOP    = 4'd9;

  localparam logic [7:0] SYM_IDLE       = 8'hF0;
  localparam logic [7:0] SYM_LINK_RESET = 8'h33;
  localparam logic [7:0] SYM_BCR        = 8'h5A;
  localparam logic [7:0] SYM_STP        = 8'h55;
  localparam logic [7:0] SYM_L1ACR      = 8'h66;
  localparam logic [7:0] SYM_CHARGE_INJ = 8'h69;
  localparam logic [7:0] SYM_L1A        = 8'h96;
  localparam logic [7:0] SYM_L1A_BCR    = 8'h99;
  localparam logic [7:0] SYM_WS_START   = 8'hA5;
  localparam logic [7:0] SYM_WS_STOP    = 8'hAA;

  localparam int NUM_CODES = 10;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_CHECK    = 2'd1,
    ST_LOCKED   = 2'd2
  } fc_state_e;

  function automatic logic [7:0] code_symbol(input logic [3:0] code);
    case (code)
      CMD_IDLE:       code_symbol = SYM_IDLE;
      CMD_LINK_RESET: code_symbol = SYM_LINK_RESET;
      CMD_BCR:        code_symbol = SYM_BCR;
      CMD_STP:        code_symbol = SYM_STP;
      CMD_L1ACR:      code_symbol = SYM_L1ACR;
      CMD_CHARGE_INJ: code_symbol = SYM_CHARGE_INJ;
      CMD_L1A:        code_symbol = SYM_L1A;
      CMD_L1A_BCR:    code_symbol = SYM_L1A_BCR;
      CMD_WS_START:   code_symbol = SYM_WS_START;
      CMD_WS_STOP:    code_symbol = SYM_WS_STOP;
      default:        code_symbol = 8'h00;
    endcase
  endfunction

  function automatic logic [3:0] hamming8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = a ^ b;
    hamming8 = 4'd0;
    for (int i = 0; i < 8; i++) begin
      hamming8 = hamming8 + {3'd0, d[i]};
    end
  endfunction

endpackage

// File: rtl/fc_symbol_decode.sv
// Combinational 8-bit symbol to 4-bit fast-command decode.
// With FC_BITFLIP_TOL_EN, single-bit errors are corrected to the unique nearest codeword.
module fc_symbol_decode
  import fc_pkg::*;
(
  input  logic [7:0] sym,
  output logic [3:0] code,
  output logic       valid
`ifdef FC_BITFLIP_TOL_EN
  ,
  output logic       corrected
`endif
);

`ifdef FC_BITFLIP_TOL_EN
  logic hit;
`endif

  // Exact codebook match, falling back to distance-1 correction when enabled
  always_comb begin
    code  = CMD_IDLE;
    valid = 1'b1;
`ifdef FC_BITFLIP_TOL_EN
    corrected = 1'b0;
    hit       = 1'b0;
`endif
    case (sym)
      SYM_IDLE:       code = CMD_IDLE;
      SYM_LINK_RESET: code = CMD_LINK_RESET;
      SYM_BCR:        code = CMD_BCR;
      SYM_STP:        code = CMD_STP;
      SYM_L1ACR:      code = CMD_L1ACR;
      SYM_CHARGE_INJ: code = CMD_CHARGE_INJ;
      SYM_L1A:        code = CMD_L1A;
      SYM_L1A_BCR:    code = CMD_L1A_BCR;
      SYM_WS_START:   code = CMD_WS_START;
      SYM_WS_STOP:    code = CMD_WS_STOP;
      default: begin
        valid = 1'b0;
`ifdef FC_BITFLIP_TOL_EN
        // Codebook distance is 4, so at most one codeword can be at distance 1
        for (int i = 0; i < NUM_CODES; i++) begin
          hit   = (hamming8(sym, code_symbol(4'(i))) == 4'd1);
          code  = hit ? 4'(i) : code;
          valid = valid | hit;
        end
        corrected = valid;
`endif
      end
    endcase
  end

endmodule

// File: rtl/fc_rx_decoder.sv
// ETROC2 fast-command receiver: IDLE alignment, symbol decode, BCID/L1A/error counters.
// Optional FC_BITFLIP_TOL_EN adds single-bit correction and the corrCnt output.
module fc_rx_decoder
  import fc_pkg::*;
#(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_ERR = 4,
  parameter int BCID_MAX   = 3563,
  parameter int BCR_OFFSET = 0,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 sdin,
  output logic                 locked,
  output logic                 cmdValid,
  output logic [3:0]           cmd,
  output logic                 symErr,
  output logic [11:0]          bcid,
  output logic [15:0]          l1aCnt,
  output logic [ERR_WIDTH-1:0] errCnt
`ifdef FC_BITFLIP_TOL_EN
  ,
  output logic [15:0]          corrCnt
`endif
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_ERR + 1);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;
  localparam logic [ERR_WIDTH-1:0] ERR_ONE = ERR_WIDTH'(1);

  fc_state_e             state_r, state_s;
  logic [6:0]            hist_r;
  logic [7:0]            sym_s;
  logic [2:0]            phase_r, phase_s;
  logic                  boundary_s;
  logic [GOOD_W-1:0]     good_r, good_s;
  logic [BAD_W-1:0]      bad_r, bad_s;
  logic                  locked_r, cmd_valid_r, cmd_valid_s, sym_err_r, sym_err_s;
  logic [3:0]            cmd_r, cmd_s;
  logic [11:0]           bcid_r, bcid_s;
  logic [15:0]           l1a_r, l1a_s;
  logic [ERR_WIDTH-1:0]  err_r, err_s;
  logic [3:0]            dec_code_s;
  logic                  dec_valid_s;
`ifdef FC_BITFLIP_TOL_EN
  logic                  dec_corr_s;
  logic [15:0]           corr_r, corr_s;
`endif

  // The symbol window includes the bit being sampled on this edge
  assign sym_s      = {hist_r, sdin};
  assign boundary_s = (phase_r == 3'd7);

  fc_symbol_decode u_decode (
    .sym       (sym_s),
    .code      (dec_code_s),
    .valid     (dec_valid_s)
`ifdef FC_BITFLIP_TOL_EN
    ,
    .corrected (dec_corr_s)
`endif
  );

  // Next-state, alignment and counter logic
  always_comb begin
    state_s     = state_r;
    phase_s     = phase_r + 3'd1;
    good_s      = good_r;
    bad_s       = bad_r;
    cmd_s       = cmd_r;
    cmd_valid_s = 1'b0;
    sym_err_s   = 1'b0;
    bcid_s      = bcid_r;
    l1a_s       = l1a_r;
    err_s       = err_r;
`ifdef FC_BITFLIP_TOL_EN
    corr_s      = corr_r;
`endif
    case (state_r)
      ST_UNLOCKED: begin
        if (sym_s == SYM_IDLE) begin
          phase_s = 3'd0;
          good_s  = GOOD_W'(1);
          state_s = ST_CHECK;
        end else begin
          good_s  = '0;
        end
      end
      ST_CHECK: begin
        if (!boundary_s) begin
          state_s = ST_CHECK;
        end else if (sym_s == SYM_IDLE) begin
          good_s  = good_r + GOOD_W'(1);
          state_s = (good_r == GOOD_W'(LOCK_CNT - 1)) ? ST_LOCKED : ST_CHECK;
        end else begin
          good_s  = '0;
          state_s = ST_UNLOCKED;
        end
      end
      ST_LOCKED: begin
        if (!boundary_s) begin
          state_s = ST_LOCKED;
        end else begin
          bcid_s = (bcid_r == 12'(BCID_MAX)) ? 12'd0 : bcid_r + 12'd1;
          if (dec_valid_s) begin
            cmd_valid_s = 1'b1;
            cmd_s       = dec_code_s;
            bad_s       = '0;
            case (dec_code_s)
              CMD_BCR:        bcid_s = 12'(BCR_OFFSET);
              CMD_L1A:        l1a_s  = l1a_r + 16'd1;
              CMD_L1A_BCR: begin
                bcid_s = 12'(BCR_OFFSET);
                l1a_s  = l1a_r + 16'd1;
              end
              CMD_L1ACR:      l1a_s  = 16'd0;
              CMD_LINK_RESET: err_s  = '0;
              default:        l1a_s  = l1a_r;
            endcase
`ifdef FC_BITFLIP_TOL_EN
            corr_s = (dec_corr_s && (corr_r != 16'hFFFF)) ? corr_r + 16'd1 : corr_r;
`endif
          end else begin
            sym_err_s = 1'b1;
            err_s     = (err_r == ERR_MAX) ? err_r : err_r + ERR_ONE;
            if (bad_r == BAD_W'(UNLOCK_ERR - 1)) begin
              bad_s   = '0;
              state_s = ST_UNLOCKED;
            end else begin
              bad_s   = bad_r + BAD_W'(1);
            end
          end
        end
      end
      default: begin
        state_s = ST_UNLOCKED;
        good_s  = '0;
        bad_s   = '0;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= ST_UNLOCKED;
      hist_r      <= 7'd0;
      phase_r     <= 3'd0;
      good_r      <= '0;
      bad_r       <= '0;
      locked_r    <= 1'b0;
      cmd_valid_r <= 1'b0;
      sym_err_r   <= 1'b0;
      cmd_r       <= 4'd0;
      bcid_r      <= 12'd0;
      l1a_r       <= 16'd0;
      err_r       <= '0;
`ifdef FC_BITFLIP_TOL_EN
      corr_r      <= 16'd0;
`endif
    end else begin
      state_r     <= state_s;
      hist_r      <= sym_s[6:0];
      phase_r     <= phase_s;
      good_r      <= good_s;
      bad_r       <= bad_s;
      locked_r    <= (state_s == ST_LOCKED);
      cmd_valid_r <= cmd_valid_s;
      sym_err_r   <= sym_err_s;
      cmd_r       <= cmd_s;
      bcid_r      <= bcid_s;
      l1a_r       <= l1a_s;
      err_r       <= err_s;
`ifdef FC_BITFLIP_TOL_EN
      corr_r      <= corr_s;
`endif
    end
  end

  assign locked   = locked_r;
  assign cmdValid = cmd_valid_r;
  assign cmd      = cmd_r;
  assign symErr   = sym_err_r;
  assign bcid     = bcid_r;
  assign l1aCnt   = l1a_r;
  assign errCnt   = err_r;
`ifdef FC_BITFLIP_TOL_EN
  assign corrCnt  = corr_r;
`endif

endmodule

// File: tb/tb_fc_rx_decoder.sv
// Scoreboard bench for fc_rx_decoder: symbol-level reference model feeds expected
// events (with their cycle) into queues; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_fc_rx_decoder;

  localparam int LOCK_CNT   = 16;
  localparam int UNLOCK_ERR = 4;
  localparam int BCID_MAX   = 3563;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sdin = 1'b0;
  logic        locked, cmdValid, symErr;
  logic [3:0]  cmd;
  logic [11:0] bcid;
  logic [15:0] l1aCnt, errCnt;
  logic [15:0] corrCnt;

  fc_rx_decoder dut (
    .clk(clk), .rstn(rstn), .sdin(sdin), .locked(locked), .cmdValid(cmdValid),
    .cmd(cmd), .symErr(symErr), .bcid(bcid), .l1aCnt(l1aCnt), .errCnt(errCnt)
`ifdef FC_BITFLIP_TOL_EN
    , .corrCnt(corrCnt)
`endif
  );

`ifndef FC_BITFLIP_TOL_EN
  assign corrCnt = 16'd0;
`endif

  always #2 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    bit          err;
    logic [3:0]  cmd;
    logic [11:0] bcid;
    logic [15:0] l1a;
    logic [15:0] errc;
    bit          lk;
    logic [15:0] corr;
  } ev_t;

  typedef struct {
    int cyc;
    bit val;
  } lk_t;

  ev_t evq[$];
  lk_t lkq[$];

  logic [7:0] syms [10] = '{8'hF0, 8'h33, 8'h5A, 8'h55, 8'h66, 8'h69, 8'h96, 8'h99, 8'hA5, 8'hAA};

  // Reference model state, symbol level
  int          m_st = 0;   // 0 hunting, 1 counting idles, 2 locked
  int          m_good = 0;
  int          m_bad = 0;
  logic [11:0] m_bcid = 12'd0;
  logic [15:0] m_l1a = 16'd0;
  logic [15:0] m_err = 16'd0;
  logic [15:0] m_corr = 16'd0;
  logic [3:0]  m_cmd = 4'd0;
  int          last_edge = 0;

  function automatic void ref_decode(input logic [7:0] s, output bit v, output logic [3:0] c,
                                     output bit corr);
    v = 1'b0; c = 4'd0; corr = 1'b0;
    for (int k = 0; k < 10; k++) if (syms[k] == s) begin v = 1'b1; c = 4'(k); end
`ifdef FC_BITFLIP_TOL_EN
    if (!v) for (int k = 0; k < 10; k++)
      if ($countones(syms[k] ^ s) == 1) begin v = 1'b1; c = 4'(k); corr = 1'b1; end
`endif
  endfunction

  function automatic void model_symbol(input logic [7:0] s, input int edge_no);
    bit v, corr;
    logic [3:0] c;
    ev_t e;
    if (m_st == 0) begin
      if (s == 8'hF0) begin m_st = 1; m_good = 1; end
    end else if (m_st == 1) begin
      if (s == 8'hF0) begin
        m_good++;
        if (m_good == LOCK_CNT) begin m_st = 2; lkq.push_back('{edge_no, 1'b1}); end
      end else begin
        m_st = 0; m_good = 0;
      end
    end else begin
      m_bcid = (m_bcid == 12'(BCID_MAX)) ? 12'd0 : m_bcid + 12'd1;
      ref_decode(s, v, c, corr);
      if (v) begin
        if (c == 4'd2 || c == 4'd7) m_bcid = 12'd0;
        if (c == 4'd6 || c == 4'd7) m_l1a = m_l1a + 16'd1;
        if (c == 4'd4) m_l1a = 16'd0;
        if (c == 4'd1) m_err = 16'd0;
        if (corr && m_corr != 16'hFFFF) m_corr = m_corr + 16'd1;
        m_bad = 0;
        m_cmd = c;
      end else begin
        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
        m_bad++;
        if (m_bad == UNLOCK_ERR) begin
          m_st = 0; m_bad = 0; m_good = 0;
          lkq.push_back('{edge_no, 1'b0});
        end
      end
      e = '{edge_no, !v, m_cmd, m_bcid, m_l1a, m_err, (m_st == 2), m_corr};
      evq.push_back(e);
    end
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    sdin = b;
    last_edge = cyc + 1;
  endtask

  task automatic send_sym(input logic [7:0] s);
    for (int i = 7; i >= 0; i--) send_bit(s[i]);
    model_symbol(s, last_edge);
  endtask

  task automatic ensure_locked();
    for (int i = 0; i < 40 && m_st != 2; i++) send_sym(8'hF0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_cmdValid"}, 32'(cmdValid), 32'd0);
    chk({tag, "_symErr"}, 32'(symErr), 32'd0);
    chk({tag, "_cmd"}, 32'(cmd), 32'd0);
    chk({tag, "_bcid"}, 32'(bcid), 32'd0);
    chk({tag, "_l1aCnt"}, 32'(l1aCnt), 32'd0);
    chk({tag, "_errCnt"}, 32'(errCnt), 32'd0);
    chk({tag, "_corrCnt"}, 32'(corrCnt), 32'd0);
  endtask

  function automatic logic [7:0] pick_sym();
    logic [7:0] s;
    int r;
    if (m_st != 2) return 8'hF0;
    r = $urandom_range(0, 9);
    s = syms[$urandom_range(0, 9)];
    if (r >= 6 && r < 8) s = s ^ (8'h01 << $urandom_range(0, 7));
    else if (r >= 8) s = 8'($urandom_range(0, 255));
    return s;
  endfunction

  // Monitor: pops expected events whenever the DUT strobes or changes lock
  bit lk_prev = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    lk_t l;
    if (cmdValid === 1'b1 || symErr === 1'b1) begin
      if (evq.size() == 0) begin
        chk("unexpected_event", {30'd0, cmdValid, symErr}, 32'd0);
      end else begin
        e = evq.pop_front();
        chk("ev_cycle", 32'(cyc), 32'(e.cyc));
        chk("cmdValid", 32'(cmdValid), 32'(!e.err));
        chk("symErr", 32'(symErr), 32'(e.err));
        chk("cmd", 32'(cmd), 32'(e.cmd));
        chk("bcid", 32'(bcid), 32'(e.bcid));
        chk("l1aCnt", 32'(l1aCnt), 32'(e.l1a));
        chk("errCnt", 32'(errCnt), 32'(e.errc));
        chk("ev_locked", 32'(locked), 32'(e.lk));
`ifdef FC_BITFLIP_TOL_EN
        chk("corrCnt", 32'(corrCnt), 32'(e.corr));
`endif
      end
    end
    if (locked !== lk_prev) begin
      if (lkq.size() == 0) begin
        chk("unexpected_lock_change", 32'(locked), 32'(lk_prev));
      end else begin
        l = lkq.pop_front();
        chk("lock_value", 32'(locked), 32'(l.val));
        chk("lock_cycle", 32'(cyc), 32'(l.cyc));
      end
      lk_prev = locked;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rst_edge;
    rstn = 1'b0;
    sdin = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rstn = 1'b1;

    // Start mid-symbol, then idle stream to lock
    repeat (3) send_bit(1'b0);
    repeat (LOCK_CNT + 2) send_sym(8'hF0);

    // L1A then L1ACR
    send_sym(8'h96);
    send_sym(8'h66);

    // BCR then increments
    send_sym(8'h5A);
    send_sym(8'hF0);
    send_sym(8'hF0);

    // Error burst below threshold, then at threshold, relock, linkReset
    repeat (3) send_sym(8'h00);
    send_sym(8'hF0);
    repeat (4) send_sym(8'h00);
    repeat (LOCK_CNT) send_sym(8'hF0);
    send_sym(8'h33);

    // Single-bit corrupted L1A
    send_sym(8'h97);
    send_sym(8'hF0);

    // BCID wrap at BCID_MAX
    send_sym(8'h5A);
    repeat (BCID_MAX + 2) send_sym(8'hF0);

    // Randomized traffic with relock whenever the model loses lock
    for (int i = 0; i < 400; i++) send_sym(pick_sym());

    // Reset in the middle of a symbol while locked
    ensure_locked();
    send_sym(8'h96);
    repeat (3) send_bit(1'($urandom_range(0, 1)));
    @(negedge clk);
    rstn = 1'b0;
    sdin = 1'b0;
    rst_edge = cyc + 1;
    if (m_st == 2) lkq.push_back('{rst_edge, 1'b0});
    m_st = 0; m_good = 0; m_bad = 0; m_bcid = 12'd0; m_l1a = 16'd0;
    m_err = 16'd0; m_corr = 16'd0; m_cmd = 4'd0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rstn = 1'b1;

    repeat (LOCK_CNT + 1) send_sym(8'hF0);
    for (int i = 0; i < 40; i++) send_sym(pick_sym());

    repeat (3) @(negedge clk);
    chk("pending_events", 32'(evq.size()), 32'd0);
    chk("pending_lock_changes", 32'(lkq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
